rggen_register_access_controller: RTL

- Bus-side initiator of the register access protocol.
- Accepts one bus request at a time and drives the registered register-side request (valid/access/address/write data/strobe) to every register's address decoder.
- Collects the per-register active/ready/status/read-data returns and produces the single bus response.
- Generates decode errors on no-match and slave errors on wait timeout.

---
 rtl/rggen_rtl_pkg.sv | 23 ++
 rtl/rggen_register_response_mux.sv | 36 +++
 rtl/rggen_register_access_controller.sv | 127 ++++++++++++
 3 files changed

// File: rtl/rggen_rtl_pkg.sv
// Shared encodings and helpers for the register access protocol.
// Access bit0 is the write flag; status codes follow the bus response encoding.
package rggen_rtl_pkg;

  localparam logic [1:0] RGGEN_READ   = 2'b10;
  localparam logic [1:0] RGGEN_WRITE  = 2'b11;

  localparam logic [1:0] RGGEN_OKAY   = 2'b00;
  localparam logic [1:0] RGGEN_SLVERR = 2'b10;
  localparam logic [1:0] RGGEN_DECERR = 2'b11;

  typedef logic [1:0] rggen_status_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/rggen_register_response_mux.sv
// Masked OR-reduction of per-register ready/status/read data; purely combinational.
// Only slots that are both active and ready contribute; overlapping matches are OR-combined.
module rggen_register_response_mux
  import rggen_rtl_pkg::*;
#(
  parameter int BUS_WIDTH = 32,
  parameter int REGISTERS = 1
)(
  input  logic [REGISTERS-1:0]           register_active,
  input  logic [REGISTERS-1:0]           register_ready,
  input  logic [2*REGISTERS-1:0]         register_status,
  input  logic [BUS_WIDTH*REGISTERS-1:0] register_read_data,
  output logic                           any_active,
  output logic                           hit,
  output rggen_status_t                  response_status,
  output logic [BUS_WIDTH-1:0]           response_read_data
);

  logic [REGISTERS-1:0] mask;

  assign mask       = register_active & register_ready;
  assign any_active = |register_active;
  assign hit        = |mask;

  always_comb begin
    response_status    = '0;
    response_read_data = '0;
    for (int i = 0; i < REGISTERS; i++) begin
      if (mask[i]) begin
        response_status    = response_status | register_status[2*i+:2];
        response_read_data = response_read_data | register_read_data[BUS_WIDTH*i+:BUS_WIDTH];
      end
    end
  end

endmodule

// File: rtl/rggen_register_access_controller.sv
// Bus-side initiator: latches one bus request, broadcasts it to the registers, returns one response.
// Read hit on the first BUSY cycle responds 2 cycles after valid; bus is ignored until the response.
module rggen_register_access_controller
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32,
  parameter int REGISTERS     = 1,
  parameter bit ERROR_STATUS  = 1'b0,
  parameter int WAIT_LIMIT    = 0
)(
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_bus_valid,
  input  logic [1:0]                     i_bus_access,
  input  logic [ADDRESS_WIDTH-1:0]       i_bus_address,
  input  logic [BUS_WIDTH-1:0]           i_bus_write_data,
  input  logic [BUS_WIDTH/8-1:0]         i_bus_strobe,
  output logic                           o_bus_ready,
  output logic [1:0]                     o_bus_status,
  output logic [BUS_WIDTH-1:0]           o_bus_read_data,
  output logic                           o_register_valid,
  output logic [1:0]                     o_register_access,
  output logic [ADDRESS_WIDTH-1:0]       o_register_address,
  output logic [BUS_WIDTH-1:0]           o_register_write_data,
  output logic [BUS_WIDTH/8-1:0]         o_register_strobe,
  input  logic [REGISTERS-1:0]           i_register_active,
  input  logic [REGISTERS-1:0]           i_register_ready,
  input  logic [2*REGISTERS-1:0]         i_register_status,
  input  logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY    = 2'd1;
  localparam logic [1:0] RESPOND = 2'd2;

  // A 1-bit counter is kept when the timeout is disabled so the declaration stays legal.
  localparam int                       COUNTER_WIDTH = (WAIT_LIMIT == 0) ? 1 : clog2(WAIT_LIMIT + 1);
  localparam logic [COUNTER_WIDTH-1:0] WAIT_LAST     = COUNTER_WIDTH'(WAIT_LIMIT - 1);
  localparam logic [1:0]               NO_MATCH      = ERROR_STATUS ? RGGEN_DECERR : RGGEN_OKAY;

  logic [1:0]               state;
  logic [COUNTER_WIDTH-1:0] wait_count;
  logic                     any_active;
  logic                     hit;
  rggen_status_t            mux_status;
  logic [BUS_WIDTH-1:0]     mux_read_data;
  logic                     timeout;

  rggen_register_response_mux #(
    .BUS_WIDTH (BUS_WIDTH),
    .REGISTERS (REGISTERS)
  ) u_response_mux (
    .register_active    (i_register_active),
    .register_ready     (i_register_ready),
    .register_status    (i_register_status),
    .register_read_data (i_register_read_data),
    .any_active         (any_active),
    .hit                (hit),
    .response_status    (mux_status),
    .response_read_data (mux_read_data)
  );

  assign timeout = (WAIT_LIMIT != 0) && (wait_count == WAIT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state                 <= IDLE;
      wait_count            <= '0;
      o_bus_ready           <= 1'b0;
      o_bus_status          <= '0;
      o_bus_read_data       <= '0;
      o_register_valid      <= 1'b0;
      o_register_access     <= '0;
      o_register_address    <= '0;
      o_register_write_data <= '0;
      o_register_strobe     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_bus_valid) begin
            state                 <= BUSY;
            wait_count            <= '0;
            o_register_valid      <= 1'b1;
            o_register_access     <= i_bus_access;
            o_register_address    <= i_bus_address;
            o_register_write_data <= i_bus_write_data;
            o_register_strobe     <= i_bus_strobe;
          end
        end
        BUSY: begin
          if (!any_active) begin
            state            <= RESPOND;
            o_register_valid <= 1'b0;
            o_bus_ready      <= 1'b1;
            o_bus_status     <= NO_MATCH;
            o_bus_read_data  <= '0;
          end else if (hit) begin
            state            <= RESPOND;
            o_register_valid <= 1'b0;
            o_bus_ready      <= 1'b1;
            o_bus_status     <= mux_status;
            o_bus_read_data  <= o_register_access[0] ? '0 : mux_read_data;
          end else if (timeout) begin
            state            <= RESPOND;
            o_register_valid <= 1'b0;
            o_bus_ready      <= 1'b1;
            o_bus_status     <= RGGEN_SLVERR;
            o_bus_read_data  <= '0;
          end else if (wait_count != '1) begin
            wait_count <= wait_count + 1'b1;
          end
        end
        RESPOND: begin
          state           <= IDLE;
          o_bus_ready     <= 1'b0;
          o_bus_status    <= '0;
          o_bus_read_data <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
